// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory/I-O responder on a shared 8-bit CPU bus. A 256x8 RAM and two
// byte-wide ports (an output FIFO and an input holding register) sit behind
// the bus. The CPU selects RAM or I/O with mem_io, qualifies the direction
// with c_ri (write) / c_ro (read), and marks each transaction with one rising
// edge of mem_clk, which is sampled and edge-detected in the clk domain.
//
// Optional feature (compile-time macro):
//   MEM_RESPONDER_PROGLOAD_EN  adds a program-load write port into the RAM
//                              (prog_we / prog_addr / prog_data) that takes
//                              priority over CPU RAM writes.
//
// Parameters
//   FIFO_DEPTH     entries in the output FIFO (power of two, 2..16)
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   addr_bus[7:0]  CPU transaction address (RAM index)
//   c_ri           CPU write strobe (CPU -> responder)
//   c_ro           CPU read strobe  (responder -> CPU)
//   mem_clk        transaction pulse, one transaction per rising edge
//   mem_io         1 = I/O port, 0 = RAM
//   bus[7:0]       shared tri-state data bus
//   out_data[7:0]  output FIFO head (8'h00 when empty)
//   out_valid      output FIFO non-empty
//   out_ready      consumer accepts the FIFO head
//   in_data[7:0]   byte offered to the input holding register
//   in_valid       in_data is valid
//   in_ready       holding register is empty and can accept
//   ovf_flag       sticky: I/O write dropped because the FIFO was full
//   unf_flag       sticky: I/O read consumed with the holding register empty
//   conflict_flag  sticky: transaction seen with c_ri and c_ro both high
//   prog_we        (optional) program-load write enable
//   prog_addr[7:0] (optional) program-load RAM address
//   prog_data[7:0] (optional) program-load RAM data
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr_bus,
  input  logic       c_ri,
  input  logic       c_ro,
  input  logic       mem_clk,
  input  logic       mem_io,
  inout  tri   [7:0] bus,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ovf_flag,
  output logic       unf_flag,
  output logic       conflict_flag
`ifdef MEM_RESPONDER_PROGLOAD_EN
  ,
  input  logic       prog_we,
  input  logic [7:0] prog_addr,
  input  logic [7:0] prog_data
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Decoded bus operation for the current cycle.
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_RAM_RD,
    OP_RAM_WR,
    OP_IO_RD,
    OP_IO_WR,
    OP_CONFLICT
  } op_e;

  op_e              op;
  logic             mem_clk_d;
  logic             tev;
  logic             act;

  logic [7:0]       ram [256];

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_req;
  logic             push;
  logic             pop;

  logic             hold_full;
  logic [7:0]       hold_data;
  logic             hold_load;
  logic             hold_take;

  logic             drive_en;
  logic [7:0]       drive_val;
  logic             ram_we;

  // ---------------------------------------------------------------------------
  // Operation decode and transaction event
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned; that is what keeps these blocks latch-free.
  always_comb begin
    op = OP_IDLE;
    if (c_ri && c_ro) begin
      op = OP_CONFLICT;
    end else if (c_ri) begin
      op = mem_io ? OP_IO_WR : OP_RAM_WR;
    end else if (c_ro) begin
      op = mem_io ? OP_IO_RD : OP_RAM_RD;
    end
  end

  // One event per mem_clk high pulse, however many clk cycles it lasts.
  assign tev = mem_clk & ~mem_clk_d;
  // An event landing on a reset edge must not touch any state.
  assign act = tev & ~reset;

  // ---------------------------------------------------------------------------
  // Bus driver: reads are combinational and do not wait for mem_clk
  // ---------------------------------------------------------------------------
  always_comb begin
    drive_en  = 1'b0;
    drive_val = 8'h00;
    unique case (op)
      OP_RAM_RD: begin
        drive_en  = 1'b1;
        drive_val = ram[addr_bus];
      end
      OP_IO_RD: begin
        drive_en  = 1'b1;
        drive_val = hold_full ? hold_data : 8'h00;
      end
      default: begin
        drive_en  = 1'b0;
        drive_val = 8'h00;
      end
    endcase
    // Keep the bus released for the whole reset window.
    if (reset) begin
      drive_en = 1'b0;
    end
  end

  assign bus = drive_en ? drive_val : 8'hzz;

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  assign ram_we = act && (op == OP_RAM_WR);

  // NOTE: the RAM array has no reset branch on purpose; a 256-entry reset
  // would prevent mapping onto memory macros and the contents are defined
  // only by writes.
  always_ff @(posedge clk) begin
`ifdef MEM_RESPONDER_PROGLOAD_EN
    // Program load owns the write port for the cycle; the CPU write is lost.
    if (prog_we) begin
      ram[prog_addr] <= prog_data;
    end else if (ram_we) begin
      ram[addr_bus] <= bus;
    end
`else
    if (ram_we) begin
      ram[addr_bus] <= bus;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign push_req   = act && (op == OP_IO_WR);
  assign pop        = ~fifo_empty & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push       = push_req & (~fifo_full | pop);

  assign out_valid  = ~fifo_empty;
  assign out_data   = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus;
    end
  end

  // ---------------------------------------------------------------------------
  // Input holding register
  // ---------------------------------------------------------------------------
  assign in_ready  = ~hold_full;
  assign hold_load = in_valid & ~hold_full;
  assign hold_take = act && (op == OP_IO_RD) && hold_full;

  // ---------------------------------------------------------------------------
  // Control state and sticky flags
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_clk_d     <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      hold_full     <= 1'b0;
      hold_data     <= 8'h00;
      ovf_flag      <= 1'b0;
      unf_flag      <= 1'b0;
      conflict_flag <= 1'b0;
    end else begin
      mem_clk_d <= mem_clk;

      // FIFO_DEPTH is a power of two, so pointer overflow is the wrap.
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // Load and take are mutually exclusive: load needs empty, take full.
      if (hold_load) begin
        hold_full <= 1'b1;
        hold_data <= in_data;
      end else if (hold_take) begin
        hold_full <= 1'b0;
      end

      if (push_req && fifo_full && !pop) begin
        ovf_flag <= 1'b1;
      end
      if (act && (op == OP_IO_RD) && !hold_full) begin
        unf_flag <= 1'b1;
      end
      if (act && (op == OP_CONFLICT)) begin
        conflict_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Scoreboard bench for mem_responder. A reference model, updated on each
// rising clk edge from the bench's own stimulus, keeps the expected FIFO
// contents as a queue, plus RAM image, holding register and flags. A separate
// monitor on the falling edge compares DUT outputs with the model and pops
// the expected queue whenever the DUT hands over a FIFO byte. Bus reads are
// compared as soon as the strobes settle. The bus net is tri1, so a
// released bus reads 8'hFF.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] addr_bus = 8'h00;
  logic       c_ri = 1'b0;
  logic       c_ro = 1'b0;
  logic       mem_clk = 1'b0;
  logic       mem_io = 1'b0;
  tri1  [7:0] bus;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       ovf_flag;
  logic       unf_flag;
  logic       conflict_flag;
`ifdef MEM_RESPONDER_PROGLOAD_EN
  logic       prog_we = 1'b0;
  logic [7:0] prog_addr = 8'h00;
  logic [7:0] prog_data = 8'h00;
`endif

  logic       tb_drive = 1'b0;
  logic [7:0] tb_bus = 8'h00;
  assign bus = tb_drive ? tb_bus : 8'hzz;

  always #5 clk = ~clk;

  mem_responder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr_bus     (addr_bus),
    .c_ri         (c_ri),
    .c_ro         (c_ro),
    .mem_clk      (mem_clk),
    .mem_io       (mem_io),
    .bus          (bus),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ovf_flag     (ovf_flag),
    .unf_flag     (unf_flag),
    .conflict_flag(conflict_flag)
`ifdef MEM_RESPONDER_PROGLOAD_EN
    ,
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  logic [7:0] ram_m [256];
  bit         ram_known [256];
  bit         m_hold_full = 1'b0;
  logic [7:0] m_hold = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;
  bit         m_conf = 1'b0;
  bit         mc_prev = 1'b0;

  always @(posedge clk) begin : model
    bit tev_m;
    bit was_full;
    bit prog_hit;
    prog_hit = 1'b0;
`ifdef MEM_RESPONDER_PROGLOAD_EN
    if (prog_we) begin
      ram_m[prog_addr]     = prog_data;
      ram_known[prog_addr] = 1'b1;
      prog_hit             = 1'b1;
    end
`endif
    tev_m    = mem_clk && !mc_prev && !reset;
    was_full = m_hold_full;
    if (reset) begin
      exp_q.delete();
      m_hold_full = 1'b0;
      m_ovf       = 1'b0;
      m_unf       = 1'b0;
      m_conf      = 1'b0;
    end else begin
      if (tev_m) begin
        if (c_ri && c_ro) begin
          m_conf = 1'b1;
        end else if (c_ri && !mem_io) begin
          if (!prog_hit) begin
            ram_m[addr_bus]     = tb_bus;
            ram_known[addr_bus] = 1'b1;
          end
        end else if (c_ri) begin
          // The monitor has already removed any byte handed over at this
          // edge, so the queue length is the room left after the pop.
          if (exp_q.size() < DEPTH) exp_q.push_back(tb_bus);
          else                      m_ovf = 1'b1;
        end else if (c_ro && mem_io) begin
          if (was_full) m_hold_full = 1'b0;
          else          m_unf = 1'b1;
        end
      end
      if (in_valid && !was_full) begin
        m_hold_full = 1'b1;
        m_hold      = in_data;
      end
    end
    mc_prev = reset ? 1'b0 : mem_clk;
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    check("out_valid", 8'(out_valid), 8'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check("out_data", out_data, exp_q[0]);
      if (out_valid && out_ready) void'(exp_q.pop_front());
    end else begin
      check("out_data_empty", out_data, 8'h00);
    end
    check("in_ready", 8'(in_ready), 8'(!m_hold_full));
    check("ovf_flag", 8'(ovf_flag), 8'(m_ovf));
    check("unf_flag", 8'(unf_flag), 8'(m_unf));
    check("conflict_flag", 8'(conflict_flag), 8'(m_conf));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  bit rnd_side = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_side) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) == 0);
      in_data   = 8'($urandom);
    end
  endtask

  function automatic bit exp_read(input logic io, input logic [7:0] a, output logic [7:0] v);
    if (io) begin
      v = m_hold_full ? m_hold : 8'h00;
      return 1'b1;
    end
    v = ram_m[a];
    return ram_known[a];
  endfunction

  // One transaction with mem_clk high for 'hi' clock edges.
  task automatic txn(input logic ri, input logic ro, input logic io,
                     input logic [7:0] a, input logic [7:0] d, input int hi = 1);
    logic [7:0] ev;
    tick();
    addr_bus = a;
    c_ri     = ri;
    c_ro     = ro;
    mem_io   = io;
    mem_clk  = 1'b1;
    tb_bus   = d;
    tb_drive = ri && !ro;
    #1;
    if (ro && !ri) begin
      if (exp_read(io, a, ev)) check(io ? "io_read_bus" : "ram_read_bus", bus, ev);
    end else if (ri && ro) begin
      check("conflict_bus_released", bus, 8'hFF);
    end
    repeat (hi) tick();
    mem_clk  = 1'b0;
    c_ri     = 1'b0;
    c_ro     = 1'b0;
    tb_drive = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : stim
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_out_valid", 8'(out_valid), 8'h00);
    check("rst_out_data", out_data, 8'h00);
    check("rst_in_ready", 8'(in_ready), 8'h01);
    check("rst_flags", {5'd0, ovf_flag, unf_flag, conflict_flag}, 8'h00);
    check("rst_bus_released", bus, 8'hFF);

    // RAM write then same-cycle combinational read
    txn(1'b1, 1'b0, 1'b0, 8'h10, 8'hA5);
    tick();
    addr_bus = 8'h10;
    c_ro     = 1'b1;
    #1;
    check("ram_read_a5", bus, 8'hA5);
    tick();
    c_ro = 1'b0;
    #1;
    check("ram_idle_bus_released", bus, 8'hFF);

    // Full FIFO with push and pop on the same edge: no overflow
    for (int i = 0; i < DEPTH; i++) txn(1'b1, 1'b0, 1'b1, 8'h00, 8'(8'hB0 + i));
    tick();
    out_ready = 1'b1;
    c_ri      = 1'b1;
    mem_io    = 1'b1;
    tb_bus    = 8'hB4;
    tb_drive  = 1'b1;
    mem_clk   = 1'b1;
    tick();
    out_ready = 1'b0;
    mem_clk   = 1'b0;
    c_ri      = 1'b0;
    tb_drive  = 1'b0;
    check("full_push_pop_no_ovf", 8'(ovf_flag), 8'h00);
    check("full_push_pop_head", out_data, 8'hB1);
    out_ready = 1'b1;
    repeat (6) tick();
    out_ready = 1'b0;
    check("drain_empty", 8'(out_valid), 8'h00);

    // Overflow: five writes into a four-entry FIFO
    for (int i = 1; i <= 5; i++) txn(1'b1, 1'b0, 1'b1, 8'h00, 8'(i));
    tick();
    check("ovf_valid", 8'(out_valid), 8'h01);
    check("ovf_flag_set", 8'(ovf_flag), 8'h01);
    for (int i = 1; i <= 4; i++) begin
      check("ovf_pop_order", out_data, 8'(i));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("ovf_drained", 8'(out_valid), 8'h00);

    // Input holding register and underflow
    tick();
    in_data  = 8'h3C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("hold_in_ready_low", 8'(in_ready), 8'h00);
    tick();
    c_ro    = 1'b1;
    mem_io  = 1'b1;
    mem_clk = 1'b1;
    #1;
    check("io_read_3c", bus, 8'h3C);
    tick();
    mem_clk = 1'b0;
    c_ro    = 1'b0;
    check("hold_in_ready_back", 8'(in_ready), 8'h01);
    tick();
    c_ro    = 1'b1;
    mem_clk = 1'b1;
    #1;
    check("io_read_empty", bus, 8'h00);
    tick();
    mem_clk = 1'b0;
    c_ro    = 1'b0;
    check("unf_flag_set", 8'(unf_flag), 8'h01);

    // mem_clk held high for three edges: one push only
    txn(1'b1, 1'b0, 1'b1, 8'h00, 8'h5C, 3);
    check("single_tev_head", out_data, 8'h5C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_tev_one_push", 8'(out_valid), 8'h00);

    // Conflict, then reset with a coinciding transaction
    txn(1'b1, 1'b0, 1'b0, 8'h40, 8'h5A);
    tick();
    in_data  = 8'h77;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    txn(1'b1, 1'b0, 1'b1, 8'h00, 8'hEE);
    txn(1'b1, 1'b1, 1'b0, 8'h40, 8'h33);
    check("conflict_flag_set", 8'(conflict_flag), 8'h01);
    tick();
    addr_bus = 8'h40;
    c_ro     = 1'b1;
    mem_io   = 1'b0;
    #1;
    check("conflict_ram_kept", bus, 8'h5A);
    tick();
    c_ro     = 1'b0;
    reset    = 1'b1;
    mem_clk  = 1'b1;
    c_ri     = 1'b1;
    mem_io   = 1'b1;
    tb_bus   = 8'h99;
    tb_drive = 1'b1;
    tick();
    reset    = 1'b0;
    mem_clk  = 1'b0;
    c_ri     = 1'b0;
    mem_io   = 1'b0;
    tb_drive = 1'b0;
    check("post_rst_flags", {5'd0, ovf_flag, unf_flag, conflict_flag}, 8'h00);
    check("post_rst_fifo", 8'(out_valid), 8'h00);
    check("post_rst_hold", 8'(in_ready), 8'h01);
    txn(1'b0, 1'b1, 1'b0, 8'h40, 8'h00);
    txn(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);

`ifdef MEM_RESPONDER_PROGLOAD_EN
    // Program load beats a same-cycle CPU write
    tick();
    prog_we   = 1'b1;
    prog_addr = 8'h20;
    prog_data = 8'h77;
    addr_bus  = 8'h20;
    c_ri      = 1'b1;
    mem_io    = 1'b0;
    tb_bus    = 8'h11;
    tb_drive  = 1'b1;
    mem_clk   = 1'b1;
    tick();
    prog_we  = 1'b0;
    mem_clk  = 1'b0;
    c_ri     = 1'b0;
    tb_drive = 1'b0;
    tick();
    c_ro = 1'b1;
    #1;
    check("prog_wins", bus, 8'h77);
    tick();
    c_ro = 1'b0;
`endif

    // Randomised traffic against the model
    rnd_side = 1'b1;
    repeat (300) begin
      int         sel;
      logic [7:0] a;
      logic [7:0] d;
      int         hi;
      sel = $urandom_range(0, 9);
      a   = 8'($urandom_range(0, 7));
      d   = 8'($urandom);
      hi  = $urandom_range(1, 2);
      case (sel)
        0, 1:    txn(1'b1, 1'b0, 1'b0, a, d, hi);
        2, 3:    txn(1'b0, 1'b1, 1'b0, a, d, hi);
        4, 5:    txn(1'b1, 1'b0, 1'b1, a, d, hi);
        6, 7:    txn(1'b0, 1'b1, 1'b1, a, d, hi);
        8:       txn(1'b1, 1'b1, 1'b0, a, d, hi);
        default: tick();
      endcase
    end
    rnd_side  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 4) tick();
    check("final_drained", 8'(out_valid), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have a parameter FIFO_DEPTH, default 4 (power of two, 2..16), which sets the number of entries in the output-port FIFO.
REQ-002 The block SHALL have the port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port addr_bus, input, 8 bits: transaction address from the CPU.
REQ-005 The block SHALL have the ports c_ri (input, 1 bit: CPU write strobe) and c_ro (input, 1 bit: CPU read strobe).
REQ-006 The block SHALL have the port mem_clk, input, 1 bit: transaction pulse; each rising edge is one transaction.
REQ-007 The block SHALL have the port mem_io, input, 1 bit: 1 selects the I/O port, 0 selects RAM.
REQ-008 The block SHALL have the port bus, inout tri, 8 bits: shared data bus.
REQ-009 The block SHALL have the ports out_data (output, 8 bits), out_valid (output, 1 bit) and out_ready (input, 1 bit): output-port FIFO head, valid/ready handshake.
REQ-010 The block SHALL have the ports in_data (input, 8 bits), in_valid (input, 1 bit) and in_ready (output, 1 bit): input-port holding register, valid/ready handshake.
REQ-011 The block SHALL have the ports ovf_flag, unf_flag and conflict_flag (outputs, 1 bit each): sticky error flags.

Function
REQ-012 Storage SHALL be 256x8 RAM indexed by addr_bus; contents are not initialised by reset.
REQ-013 Transaction event (tev) SHALL be mem_clk==1 while registered mem_clk_d==0; exactly one tev per mem_clk high pulse, acted on in that clk cycle.
REQ-014 RAM read SHALL drive bus = ram[addr_bus] combinationally, same cycle, whenever c_ro=1, c_ri=0 and mem_io=0, independent of mem_clk.
REQ-015 RAM write SHALL set ram[addr_bus] <= bus on tev with c_ri=1, c_ro=0 and mem_io=0.
REQ-016 I/O read SHALL drive bus = holding register combinationally whenever c_ro=1, c_ri=0, mem_io=1 and the holding register is full, and SHALL drive 8'h00 when it is empty.
REQ-017 On tev during an I/O read, a full holding register SHALL become empty on the next edge; an empty one SHALL set unf_flag.
REQ-018 Input holding register: in_ready = ~full; load in_data when in_valid & in_ready; load and consume in the same cycle is impossible (in_ready=0 while full).
REQ-019 I/O write (tev, c_ri=1, c_ro=0, mem_io=1) SHALL push bus into the FIFO; when the FIFO is full the byte is dropped and ovf_flag is set.
REQ-020 FIFO SHALL pop on out_valid & out_ready; out_valid = ~empty; out_data = head entry (8'h00 when empty); push and pop in the same cycle on a full FIFO SHALL both succeed (count unchanged, no overflow).
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be FIFO_DEPTH+1 states wide.
REQ-022 c_ri=1 and c_ro=1 together SHALL leave bus undriven and perform no access; conflict_flag SHALL be set on tev.
REQ-023 The block SHALL drive bus to 8'hZZ in every case not covered by REQ-014 and REQ-016.
REQ-024 Flags SHALL be sticky until reset.

Reset
REQ-025 On reset: FIFO empty, out_valid=0, out_data=8'h00, holding register empty, in_ready=1, all flags 0, mem_clk_d=0, bus=8'hZZ.
REQ-026 Reset mid-operation SHALL discard FIFO and holding contents; a tev coinciding with reset SHALL have no effect; RAM SHALL be untouched.

Configuration
REQ-027 With MEM_RESPONDER_PROGLOAD_EN defined, the block SHALL add ports prog_we (in, 1 bit), prog_addr (in, 8 bits) and prog_data (in, 8 bits); prog_we=1 writes ram[prog_addr] <= prog_data each clk, and wins over a same-cycle CPU RAM write to any address.
REQ-028 Without MEM_RESPONDER_PROGLOAD_EN, those ports SHALL be absent and RAM SHALL be written only by the CPU.

Verification
REQ-029 RAM write/read: write 8'hA5 to 8'h10 via c_ri + mem_clk pulse, then assert c_ro with addr 8'h10 -> bus=8'hA5 in the same cycle; with c_ro low -> bus=ZZ.
REQ-030 Output FIFO: 5 I/O writes (8'h01..8'h05) with out_ready=0, depth 4 -> out_valid=1, ovf_flag=1, then pops yield 01,02,03,04 and out_valid=0.
REQ-031 Input port: in_data=8'h3C, in_valid=1 for one cycle -> in_ready=0; I/O read -> bus=8'h3C; after tev in_ready=1; second I/O read -> bus=8'h00 and unf_flag=1.
REQ-032 Single tev: mem_clk held high 3 cycles with an I/O write -> exactly one FIFO push.
REQ-033 Conflict/reset: c_ri=c_ro=1 plus tev -> bus=ZZ, RAM unchanged, conflict_flag=1; reset then clears the flag, FIFO and holding register.
REQ-034 With MEM_RESPONDER_PROGLOAD_EN: prog_we writes 8'h77 to 8'h20 in the same cycle as a CPU write of 8'h11 to 8'h20 -> a later read returns 8'h77.
